// File: rtl/axi4s2packet_capture.sv
// -----------------------------------------------------------------------------
// axi4s2packet_capture
// AXI4-Stream sink that captures one packet into a word-wide buffer and
// exposes it as a byte-addressable array with a byte length. Holds one packet
// at a time and backpressures (tready=0) until the consumer releases it.
//
// Handshake: a beat transfers on a rising clk edge where tvalid && tready.
// tready is decoded purely from the state register (RECV or DROP), so it
// never depends combinationally on any input.
//
// Ports
//   clk           clock, all logic on posedge
//   rst           synchronous reset, active-low
//   tdata/tlast/tvalid/tready   AXI4-Stream slave; byte lane k = tdata[k*8 +: 8]
//   pkt_valid     a captured packet is available
//   pkt_len       bytes stored (stored beats * bytes per beat, pad included)
//   pkt_beats     beats received, including dropped ones (saturating)
//   pkt_overflow  packet did not fit; tail beats were dropped
//   pkt_release   consumer done with the packet (only honoured when valid)
//   rd_addr       byte read address
//   rd_data       byte at rd_addr, one cycle after the address
//   dbg_state     current FSM state for observation
// -----------------------------------------------------------------------------
module axi4s2packet_capture #(
  parameter int AXI_WIDTH = 64,
  parameter int MAX_BYTES = 2048,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1),
  parameter int ADDR_W    = $clog2(MAX_BYTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AXI_WIDTH-1:0] tdata,
  input  logic                 tlast,
  input  logic                 tvalid,
  output logic                 tready,
  output logic                 pkt_valid,
  output logic [LEN_W-1:0]     pkt_len,
  output logic [LEN_W-1:0]     pkt_beats,
  output logic                 pkt_overflow,
  input  logic                 pkt_release,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [7:0]           rd_data,
  output logic [1:0]           dbg_state
);

  localparam int BPW    = AXI_WIDTH / 8;
  localparam int DEPTH  = MAX_BYTES / BPW;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_beats;
  logic                 r_overflow;
  logic [7:0]           r_rd_data;
  logic [AXI_WIDTH-1:0] r_mem [DEPTH];

  logic                 w_accept;
  logic                 w_wr;
  logic [PTR_W-1:0]     w_rd_word;
  logic [LANE_W-1:0]    w_rd_lane;
  logic [AXI_WIDTH-1:0] w_rd_word_data;

  assign tready       = (r_state == S_RECV) || (r_state == S_DROP);
  assign pkt_valid    = (r_state == S_DONE);
  assign pkt_len      = r_len;
  assign pkt_beats    = r_beats;
  assign pkt_overflow = r_overflow;
  assign rd_data      = r_rd_data;
  assign dbg_state    = r_state;

  assign w_accept = tvalid && tready;
  assign w_wr     = w_accept && (r_state == S_RECV);

  // Control FSM. wr_ptr only ever needs to reach DEPTH-1: the beat written
  // there either ends the packet or switches to DROP, so the wrap is harmless.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_len      <= '0;
      r_beats    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wr_ptr   <= '0;
          r_len      <= '0;
          r_beats    <= '0;
          r_overflow <= 1'b0;
          r_state    <= S_RECV;
        end
        S_RECV: begin
          if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_len    <= r_len + LEN_W'(BPW);
            r_beats  <= r_beats + 1'b1;
            if (tlast) begin
              r_state <= S_DONE;
            end else if (r_wr_ptr == PTR_W'(DEPTH - 1)) begin
              r_state <= S_DROP;
            end
          end
        end
        S_DROP: begin
          if (w_accept) begin
            if (r_beats != '1) begin
              r_beats <= r_beats + 1'b1;
            end
            r_overflow <= 1'b1;
            if (tlast) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (pkt_release) begin
            r_wr_ptr   <= '0;
            r_len      <= '0;
            r_beats    <= '0;
            r_overflow <= 1'b0;
            r_state    <= S_RECV;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= tdata;
    end
  end

  // Byte read: word = addr / BPW, lane = addr % BPW. Registered, so a read of
  // the word being written in the same cycle returns the previous contents.
  assign w_rd_word      = PTR_W'(rd_addr / ADDR_W'(BPW));
  assign w_rd_lane      = LANE_W'(rd_addr % ADDR_W'(BPW));
  assign w_rd_word_data = r_mem[w_rd_word];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= w_rd_word_data[w_rd_lane*8 +: 8];
    end
  end

endmodule
